// File: rtl/kernel_4_div_pkg.sv
// kernel_4 divider shared types and constants.
// Widths, FSM states and overflow result values.
package kernel_4_div_pkg;

  localparam int DIVIDEND_W = 31;
  localparam int DIVISOR_W  = 16;
  localparam int QUOT_W     = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [QUOT_W-1:0]    OVF_QUOT = 15'h7FFF;
  localparam logic [DIVISOR_W-1:0] OVF_REM  = 16'hFFFF;

endpackage

// File: rtl/kernel_4_udiv_31ns_16ns_15_seq_step.sv
// One restoring division step.
// Shifts in a dividend bit and subtracts when it fits.
module kernel_4_udiv_31ns_16ns_15_seq_step
  import kernel_4_div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] pr,
  input  logic                 dbit,
  input  logic [DIVISOR_W-1:0] dvsr,
  output logic [DIVISOR_W:0]   npr,
  output logic                 qbit
);

  logic [DIVISOR_W:0] t;

  // 17-bit compare/subtract so a shifted PR >= 2^16 is handled
  always_comb begin
    t    = {pr, dbit};
    npr  = t;
    qbit = 1'b0;
    if (t >= {1'b0, dvsr}) begin
      npr  = t - {1'b0, dvsr};
      qbit = 1'b1;
    end
  end

endmodule

// File: rtl/kernel_4_udiv_31ns_16ns_15_seq.sv
// Sequential unsigned restoring divider, 31/16 -> 15q,16r.
// Fixed 16-cycle latency, valid/ready on both sides.
module kernel_4_udiv_31ns_16ns_15_seq #(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          DIVIDEND_W = 31,
  parameter int          DIVISOR_W  = 16,
  parameter int          QUOT_W     = 15
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [QUOT_W-1:0]     quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  ovf
);

  import kernel_4_div_pkg::*;

  state_t          state;
  state_t          nstate;
  logic [16:0]     pr;
  logic [16:0]     npr;
  logic [14:0]     sh;
  logic [14:0]     q;
  logic [15:0]     dv;
  logic [3:0]      cnt;
  logic            ovf_r;
  logic            qb;
  logic            acc;
  logic [14:0]     quot_r;
  logic [15:0]     rem_r;
  logic            ovf_o;

  logic [31:0]     unused_id;
  logic            unused_pr16;

  assign unused_id   = ID;
  assign unused_pr16 = pr[16];

  assign acc     = in_vld & in_rdy;
  assign out_vld = (state == DONE);
  assign quot    = quot_r;
  assign rem     = rem_r;
  assign ovf     = ovf_o;

  kernel_4_udiv_31ns_16ns_15_seq_step u_step (
    .pr   (pr[15:0]),
    .dbit (sh[14]),
    .dvsr (dv),
    .npr  (npr),
    .qbit (qb)
  );

  // next state and input-side ready
  always_comb begin
    nstate = state;
    in_rdy = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) nstate = CALC;
      end
      CALC: begin
        if (cnt == 4'd15) nstate = DONE;
      end
      DONE: begin
        in_rdy = out_rdy;
        if (out_rdy) nstate = in_vld ? CALC : IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // 15 steps on cnt 0..14, result latch on cnt 15
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= IDLE;
      pr     <= '0;
      sh     <= '0;
      q      <= '0;
      dv     <= '0;
      cnt    <= '0;
      ovf_r  <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      state <= nstate;
      if (acc) begin
        pr    <= {1'b0, din0[30:15]};
        sh    <= din0[14:0];
        dv    <= din1;
        q     <= '0;
        cnt   <= '0;
        ovf_r <= (din1 == 16'd0) | (din0[30:15] >= din1);
      end else if (state == CALC) begin
        if (cnt != 4'd15) begin
          pr  <= npr;
          sh  <= {sh[13:0], 1'b0};
          q   <= {q[13:0], qb};
          cnt <= cnt + 4'd1;
        end else begin
          quot_r <= ovf_r ? OVF_QUOT : q;
          rem_r  <= ovf_r ? OVF_REM : pr[15:0];
          ovf_o  <= ovf_r;
        end
      end
    end
  end

endmodule
